// File: rtl/bus_wrr_arbiter.sv
// Weighted round-robin bus arbiter: one-hot grant per device, burst credit, stall watchdog.
// Latency: 1 cycle from pending (in IDLE) to grant; release is followed by a 1-cycle GAP plus 1 IDLE cycle.
// Backpressure: a grant holds until its credit is used, its pending flag drops, or the watchdog fires.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   pndng[drvrs]        - per-device packet waiting
//   xfer_done           - granted device completed one packet (ignored when not granting)
//   cfg_we/idx/wgt      - weight write port (idx >= drvrs ignored, weight 0 masks the device)
//   gnt, gnt_vld        - one-hot grant and its valid
//   gnt_id              - binary grantee index, holds its last value while idle
//   tmo_err             - one-cycle pulse when the watchdog revokes a grant
module bus_wrr_arbiter #(
    parameter int drvrs = 5,
    parameter int wgt_w = 4,
    parameter int tmo   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic                     xfer_done,
    input  logic                     cfg_we,
    input  logic [$clog2(drvrs)-1:0] cfg_idx,
    input  logic [wgt_w-1:0]         cfg_wgt,
    output logic [drvrs-1:0]         gnt,
    output logic                     gnt_vld,
    output logic [$clog2(drvrs)-1:0] gnt_id,
    output logic                     tmo_err
);

    localparam int id_w = $clog2(drvrs);
    localparam int wd_w = $clog2(tmo);

    localparam logic [id_w:0]      drvrs_c = (id_w + 1)'(drvrs);
    localparam logic [id_w-1:0]    last_id = id_w'(drvrs - 1);
    localparam logic [drvrs-1:0]   one_hot0 = drvrs'(1);
    localparam logic [wd_w-1:0]    wd_last = wd_w'(tmo - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state, state_n;
    logic [id_w-1:0]  ptr, ptr_n;
    logic [wgt_w-1:0] credit, credit_n;
    logic [wd_w-1:0]  wdog, wdog_n;
    logic [drvrs-1:0] gnt_n;
    logic [id_w-1:0]  gnt_id_n;
    logic             tmo_err_n;
    logic [wgt_w-1:0] wgt [drvrs];

    // Rotating priority search starting at ptr.
    logic             any_elig;
    logic [id_w-1:0]  win;
    logic [id_w-1:0]  idx;
    logic             rel;

    always_comb begin
        any_elig = 1'b0;
        win      = '0;
        idx      = '0;
        // Walk offsets from farthest to nearest so the nearest eligible
        // device (ptr itself first) is the one left in win.
        for (int k = drvrs - 1; k >= 0; k--) begin
            idx = id_w'((int'(ptr) + k) % drvrs);
            if (pndng[idx] && (wgt[idx] != '0)) begin
                any_elig = 1'b1;
                win      = idx;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        credit_n  = credit;
        wdog_n    = wdog;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        tmo_err_n = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    gnt_n    = one_hot0 << win;
                    gnt_id_n = win;
                    credit_n = wgt[win];
                    wdog_n   = '0;
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                if (xfer_done) begin
                    credit_n = credit - wgt_w'(1);
                    wdog_n   = '0;
                    if (credit == wgt_w'(1)) begin
                        rel = 1'b1;
                    end
                end else if (wdog == wd_last) begin
                    // tmo cycles in a row without a completed transfer.
                    rel       = 1'b1;
                    tmo_err_n = 1'b1;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
                // Dropping the request releases even if a done arrives with it;
                // that done has already been charged above.
                if (!pndng[gnt_id]) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    gnt_n   = '0;
                    ptr_n   = (gnt_id == last_id) ? '0 : gnt_id + 1'b1;
                    state_n = GAP;
                end
            end
            GAP: begin
                // Bus turnaround cycle; arbitration resumes from IDLE.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            credit  <= '0;
            wdog    <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            tmo_err <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            credit  <= credit_n;
            wdog    <= wdog_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            tmo_err <= tmo_err_n;
        end
    end

    // Weights only feed the next grant load; the running credit is untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < drvrs; i++) begin
                wgt[i] <= wgt_w'(1);
            end
        end else if (cfg_we && ({1'b0, cfg_idx} < drvrs_c)) begin
            wgt[cfg_idx] <= cfg_wgt;
        end
    end

    assign gnt_vld = |gnt;

endmodule
